// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - round-robin scanned multi-channel input debouncer with sticky change flags
// Optional registered interrupt output is built only when DEBOUNCE_IRQ_EN is defined.
module debounce_scheduler #(
    parameter int NCH = 8,
    parameter int CW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick_en,
    input  logic [NCH-1:0] bits_in,
    input  logic [CW-1:0]  thresh,
    input  logic [NCH-1:0] chg_ack,
    input  logic [NCH-1:0] irq_mask,
    output logic [NCH-1:0] bits_out,
    output logic [NCH-1:0] chg_flags,
    output logic [3:0]     scan_ch,
    output logic           irq
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PW-1:0] LAST_CH = PW'(NCH - 1);

    logic [NCH-1:0] sync1_q, sync1_d;
    logic [NCH-1:0] sync2_q, sync2_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NCH-1:0] last_q, last_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] bits_out_q, bits_out_d;
    logic [NCH-1:0] chg_flags_q, chg_flags_d;
    logic [NCH-1:0] chg_set;
    logic           sample;

    always_comb begin
        sync1_d    = bits_in;
        sync2_d    = sync1_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        bits_out_d = bits_out_q;
        chg_set    = '0;
        sample     = sync2_q[ptr_q];
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        // Only the channel under the scan pointer is evaluated on a tick.
        if (tick_en) begin
            last_d[ptr_q] = sample;
            if (sample != last_q[ptr_q]) begin
                cnt_d[ptr_q] = '0;
            end else if ((cnt_q[ptr_q] >= thresh) && (sample != bits_out_q[ptr_q])) begin
                bits_out_d[ptr_q] = sample;
                chg_set[ptr_q]    = 1'b1;
                cnt_d[ptr_q]      = '0;
            end else if (cnt_q[ptr_q] != {CW{1'b1}}) begin
                cnt_d[ptr_q] = cnt_q[ptr_q] + CW'(1);
            end
            ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + PW'(1);
        end
        // A new change wins over an acknowledge landing in the same cycle.
        chg_flags_d = (chg_flags_q & ~chg_ack) | chg_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            ptr_q       <= '0;
            last_q      <= '0;
            bits_out_q  <= '0;
            chg_flags_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            bits_out_q  <= bits_out_d;
            chg_flags_q <= chg_flags_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bits_out  = bits_out_q;
    assign chg_flags = chg_flags_q;
    assign scan_ch   = 4'(ptr_q);

`ifdef DEBOUNCE_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = |(chg_flags_q & irq_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_mask;

    assign unused_irq_mask = ^irq_mask;
    assign irq             = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - randomized bench for debounce_scheduler against a behavioural channel model
module tb_debounce_scheduler;
    localparam int NCH  = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef DEBOUNCE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           tick_en = 1'b0;
    logic [NCH-1:0] bits_in = '0;
    logic [CW-1:0]  thresh = '0;
    logic [NCH-1:0] chg_ack = '0;
    logic [NCH-1:0] irq_mask = '0;
    logic [NCH-1:0] bits_out;
    logic [NCH-1:0] chg_flags;
    logic [3:0]     scan_ch;
    logic           irq;

    int n_checks = 0;
    int n_errors = 0;

    debounce_scheduler #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .bits_in(bits_in),
        .thresh(thresh), .chg_ack(chg_ack), .irq_mask(irq_mask),
        .bits_out(bits_out), .chg_flags(chg_flags), .scan_ch(scan_ch), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: per channel, remember the previous sample and how many
    // consecutive matching visits have been seen; the input reaches the model
    // through a two-sample delay line.
    int       m_last [NCH];
    int       m_run  [NCH];
    bit [7:0] m_out, m_flags, m_d1, m_d2, m_set, m_prev;
    int       m_ptr;
    bit       m_irq;
    int       m_k;
    bit       m_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_last[i] = 0;
                m_run[i]  = 0;
            end
            m_out = 0; m_flags = 0; m_d1 = 0; m_d2 = 0; m_ptr = 0; m_irq = 0;
        end else begin
            m_set  = 0;
            m_prev = m_flags;
            if (tick_en) begin
                m_k = m_ptr;
                m_s = m_d2[m_k];
                if (int'(m_s) != m_last[m_k]) begin
                    m_run[m_k] = 0;
                end else if (m_run[m_k] >= int'(thresh) && m_s != m_out[m_k]) begin
                    m_out[m_k] = m_s;
                    m_set[m_k] = 1'b1;
                    m_run[m_k] = 0;
                end else begin
                    m_run[m_k] = (m_run[m_k] + 1 > CMAX) ? CMAX : m_run[m_k] + 1;
                end
                m_last[m_k] = int'(m_s);
                m_ptr = (m_ptr + 1) % NCH;
            end
            m_flags = (m_flags & ~chg_ack) | m_set;
            m_irq   = IRQ_EN && ((m_prev & irq_mask) != 0);
            m_d2 = m_d1;
            m_d1 = bits_in;
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; tick_en = 1'b1; thresh = 4'd1;
        for (int c = 0; c < 29; c++) begin
            bits_in = NCH'($urandom);
            cycle();
        end
        bits_in = 8'hFF; thresh = 4'd9; rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bits_out, chg_flags, scan_ch, irq} !== 21'd0) begin
            n_errors++;
            $display("FAIL reset_async: got %h required 0", {bits_out, chg_flags, scan_ch, irq});
        end
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            cycle();
            n_checks++;
            if ({bits_out, chg_flags, scan_ch, irq} !== 21'd0) begin
                n_errors++;
                $display("FAIL reset_hold: got %h required 0", {bits_out, chg_flags, scan_ch, irq});
            end
        end
    endtask

    task automatic test_all_high();
        rst_n = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            cycle();
            n_checks++;
            if ({bits_out, chg_flags, scan_ch, irq} !== {m_out, m_flags, 4'(m_ptr), m_irq}) begin
                n_errors++;
                $display("FAIL all_high_model edge %0d: got %h required %h", e,
                         {bits_out, chg_flags, scan_ch, irq}, {m_out, m_flags, 4'(m_ptr), m_irq});
            end
            if (e == 83 || e == 84) begin
                n_checks++;
                if (bits_out[3] !== (e == 84)) begin
                    n_errors++;
                    $display("FAIL all_high_ch3_visit edge %0d: got %b required %b", e, bits_out[3], e == 84);
                end
            end
        end
        n_checks++;
        if ({bits_out, chg_flags} !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL all_high_final: got %h required ffff", {bits_out, chg_flags});
        end
    endtask

    task automatic test_short_glitch();
        bits_in = '0; do_reset(); thresh = 4'd9; tick_en = 1'b1;
        for (int c = 0; c < 150; c++) begin
            bits_in = (c >= 10 && c < 50) ? 8'h08 : 8'h00;
            cycle();
            n_checks++;
            if ({bits_out, chg_flags, scan_ch, irq} !== {m_out, m_flags, 4'(m_ptr), m_irq}) begin
                n_errors++;
                $display("FAIL glitch_model cyc %0d: got %h required %h", c,
                         {bits_out, chg_flags, scan_ch, irq}, {m_out, m_flags, 4'(m_ptr), m_irq});
            end
        end
        n_checks++;
        if (bits_out[3] !== 1'b0 || chg_flags[3] !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_ch3: got out=%b flag=%b required 0 0", bits_out[3], chg_flags[3]);
        end
    endtask

    task automatic test_ack_collision();
        bit found = 0;
        bits_in = '0; do_reset(); thresh = 4'd0; tick_en = 1'b1; bits_in = 8'h04;
        for (int c = 0; c < 40 && !found; c++) begin
            if (m_ptr == 2 && int'(m_d2[2]) == m_last[2] && m_d2[2] != m_out[2]) begin
                found = 1;
                chg_ack = 8'h04;
            end
            cycle();
            chg_ack = '0;
        end
        n_checks++;
        if (!found || chg_flags[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL ack_collision: found=%0d got %b required 1", found, chg_flags[2]);
        end
        cycle();
        n_checks++;
        if (chg_flags[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL ack_sticky: got %b required 1", chg_flags[2]);
        end
        chg_ack = 8'h04;
        cycle();
        chg_ack = '0;
        n_checks++;
        if (chg_flags[2] !== 1'b0 || chg_flags !== m_flags) begin
            n_errors++;
            $display("FAIL ack_clear: got %h required %h with bit2 0", chg_flags, m_flags);
        end
    endtask

    task automatic test_thresh_zero();
        bits_in = '0; do_reset(); thresh = 4'd0; tick_en = 1'b1;
        for (int c = 0; c < 20 && m_ptr != 6; c++) cycle();
        bits_in = 8'h01;
        for (int e = 1; e <= 12; e++) begin
            cycle();
            if (e == 3 || e == 10 || e == 11) begin
                n_checks++;
                if (bits_out[0] !== (e == 11) || bits_out !== m_out) begin
                    n_errors++;
                    $display("FAIL thresh0 edge %0d: got %h required bit0=%b model %h", e, bits_out, e == 11, m_out);
                end
            end
        end
    endtask

    task automatic test_idle();
        bit [7:0] exp_out, exp_flags;
        bit [3:0] exp_ch;
        exp_out = m_out; exp_flags = m_flags; exp_ch = 4'(m_ptr);
        tick_en = 1'b0;
        for (int c = 0; c < 100; c++) begin
            bits_in = NCH'($urandom);
            cycle();
            n_checks++;
            if ({bits_out, chg_flags, scan_ch} !== {exp_out, exp_flags, exp_ch}) begin
                n_errors++;
                $display("FAIL idle cyc %0d: got %h required %h", c,
                         {bits_out, chg_flags, scan_ch}, {exp_out, exp_flags, exp_ch});
            end
        end
    endtask

    task automatic test_irq();
        bit found = 0;
        bits_in = '0; do_reset(); irq_mask = 8'h04; thresh = 4'd0; tick_en = 1'b1; bits_in = 8'h02;
        for (int c = 0; c < 24; c++) begin
            cycle();
            n_checks++;
            if (irq !== 1'b0 || chg_flags !== m_flags) begin
                n_errors++;
                $display("FAIL irq_masked cyc %0d: got irq=%b flags=%h required 0 %h", c, irq, chg_flags, m_flags);
            end
        end
        bits_in = 8'h06;
        for (int c = 0; c < 40 && !found; c++) begin
            cycle();
            if (chg_flags[2]) found = 1;
        end
        n_checks++;
        if (!found || irq !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_same_cycle: found=%0d got %b required 0", found, irq);
        end
        cycle();
        n_checks++;
        if (irq !== IRQ_EN) begin
            n_errors++;
            $display("FAIL irq_next_cycle: got %b required %b", irq, IRQ_EN);
        end
        irq_mask = '0;
    endtask

    task automatic test_random();
        bits_in = '0; do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick_en = ($urandom_range(3) != 0);
            for (int b = 0; b < NCH; b++) begin
                if ($urandom_range(23) == 0) bits_in[b] = ~bits_in[b];
            end
            if ($urandom_range(63) == 0) thresh = CW'($urandom_range(CMAX));
            if ($urandom_range(99) == 0) irq_mask = NCH'($urandom);
            chg_ack = ($urandom_range(7) == 0) ? NCH'($urandom) : '0;
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            cycle();
            n_checks++;
            if ({bits_out, chg_flags, scan_ch, irq} !== {m_out, m_flags, 4'(m_ptr), m_irq}) begin
                n_errors++;
                $display("FAIL random_model cyc %0d: got %h required %h", c,
                         {bits_out, chg_flags, scan_ch, irq}, {m_out, m_flags, 4'(m_ptr), m_irq});
            end
        end
        chg_ack = '0;
    endtask

    initial begin
        @(negedge clk);
        cycle();
        test_reset();
        test_all_high();
        test_short_glitch();
        test_ack_collision();
        test_thresh_zero();
        test_idle();
        test_irq();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
